// File: rtl/shift_add_multiplier_32bit.sv
// Sequential 32x32 unsigned shift-and-add multiplier.
// One add/shift iteration per clock, 32 iterations, 64-bit registered product.

module rca32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [32:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_fa
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_c[32];
endmodule

module shift_add_multiplier_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_m;
    logic [31:0] r_q;
    logic [31:0] r_a;
    logic        r_c;
    logic [5:0]  r_cnt;
    logic [63:0] r_product;

    logic [31:0] w_sum;
    logic        w_cout;
    logic [31:0] w_add_a;
    logic        w_add_c;
    logic [31:0] w_a_next;
    logic [31:0] w_q_next;

    rca32 u_adder (
        .i_a   (r_a),
        .i_b   (r_m),
        .i_cin (1'b0),
        .o_sum (w_sum),
        .o_cout(w_cout)
    );

    // C is always cleared by the shift, so the no-add path keeps {C,A} = {0,A}.
    assign w_add_a  = r_q[0] ? w_sum  : r_a;
    assign w_add_c  = r_q[0] ? w_cout : r_c;
    assign w_a_next = {w_add_c, w_add_a[31:1]};
    assign w_q_next = {w_add_a[0], r_q[31:1]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == 6'd31) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_q       <= '0;
            r_a       <= '0;
            r_c       <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m   <= a;
                        r_q   <= b;
                        r_a   <= '0;
                        r_c   <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_c   <= 1'b0;
                    r_cnt <= r_cnt + 6'd1;
                    // Final iteration: capture the shifted result directly.
                    if (r_cnt == 6'd31)
                        r_product <= {w_a_next, w_q_next};
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
endmodule

// File: tb/tb_shift_add_multiplier_32bit.sv
// Scoreboard bench for the shift-add multiplier: expected products are queued
// at issue time and popped when done is observed.

module tb_shift_add_multiplier_32bit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [63:0] product;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];

    shift_add_multiplier_32bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .product(product),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Drive one start cycle from IDLE and queue the expected product.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        sb_q.push_back(64'(ia) * 64'(ib));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges after acceptance until done (bounded); optionally pulse
    // start with new operands in the middle of the run.
    task automatic wait_done(input int inject_at, output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = busy;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == inject_at) begin
                a = 32'd9;
                b = 32'd9;
                start = 1'b1;
            end else if (cyc == inject_at + 1) begin
                start = 1'b0;
                a = $urandom;
                b = $urandom;
            end
            if (!done && !busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if (product !== 64'd0) begin n_fail++; $display("FAIL reset_product actual=%h required=0", product); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done actual=%b required=0", done); end
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_vectors;
        logic [31:0] ta[9];
        logic [31:0] tb[9];
        logic [63:0] exp;
        int cyc;
        bit bok;
        ta = '{32'd3, 32'd0, 32'hFFFFFFFF, 32'd65536, 32'd1000000000, 32'd1, 32'h80000000, 32'd0, 32'd0};
        tb = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd65536, 32'd4, 32'h80000001, 32'h80000000, 32'd0, 32'd0};
        for (int i = 7; i < 9; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
        end
        for (int i = 0; i < 9; i++) begin
            issue(ta[i], tb[i]);
            a = $urandom;
            b = $urandom;
            wait_done(-1, cyc, bok);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
            $display("txn a=%h b=%h product=%h expected=%h cycles=%0d", ta[i], tb[i], product, exp, cyc);
            n_checks++;
            if (cyc !== 32) begin n_fail++; $display("FAIL latency[%0d] actual=%0d required=32", i, cyc); end
            n_checks++;
            if (!bok) begin n_fail++; $display("FAIL busy_during_run[%0d] actual=0 required=1", i); end
            n_checks++;
            if (product !== exp) begin n_fail++; $display("FAIL product[%0d] actual=%h required=%h", i, product, exp); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_in_done[%0d] actual=%b required=0", i, busy); end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL done_width[%0d] actual=%b required=0", i, done); end
            @(negedge clk);
            n_checks++;
            if (product !== exp) begin n_fail++; $display("FAIL product_hold[%0d] actual=%h required=%h", i, product, exp); end
        end
    endtask

    task automatic test_start_during_run;
        logic [63:0] exp;
        int cyc;
        int extra;
        bit bok;
        issue(32'd7, 32'd6);
        wait_done(10, cyc, bok);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
        $display("txn a=7 b=6 (start pulsed mid-run) product=%h expected=%h cycles=%0d", product, exp, cyc);
        n_checks++;
        if (cyc !== 32) begin n_fail++; $display("FAIL run_ignore_latency actual=%0d required=32", cyc); end
        n_checks++;
        if (product !== exp) begin n_fail++; $display("FAIL run_ignore_product actual=%h required=%h", product, exp); end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL run_ignore_extra_done actual=%0d required=0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp;
        int cyc;
        bit bok;
        issue(32'd100, 32'd200);
        wait_done(-1, cyc, bok);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
        $display("txn a=100 b=200 product=%h expected=%h cycles=%0d", product, exp, cyc);
        n_checks++;
        if (product !== exp) begin n_fail++; $display("FAIL b2b_first_product actual=%h required=%h", product, exp); end
        // Start held high while in DONE must be ignored.
        a = 32'd1;
        b = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL done_ignore_start actual=%b required=0", busy); end
        issue(32'd300, 32'd400);
        wait_done(-1, cyc, bok);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
        $display("txn a=300 b=400 product=%h expected=%h cycles=%0d", product, exp, cyc);
        n_checks++;
        if (cyc !== 32) begin n_fail++; $display("FAIL b2b_latency actual=%0d required=32", cyc); end
        n_checks++;
        if (product !== exp) begin n_fail++; $display("FAIL b2b_product actual=%h required=%h", product, exp); end
    endtask

    task automatic test_reset_abort;
        logic [63:0] exp;
        int cyc;
        int seen_done;
        int seen_busy;
        bit bok;
        issue(32'd12, 32'd12);
        repeat (14) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before actual=%b required=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        $display("txn reset asserted mid-run product=%h busy=%b done=%b", product, busy, done);
        n_checks++;
        if (product !== 64'd0) begin n_fail++; $display("FAIL abort_product actual=%h required=0", product); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy actual=%b required=0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done actual=%b required=0", done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        seen_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        n_checks++;
        if (seen_done !== 0) begin n_fail++; $display("FAIL abort_no_done actual=%0d required=0", seen_done); end
        n_checks++;
        if (seen_busy !== 0) begin n_fail++; $display("FAIL abort_stays_idle actual=%0d required=0", seen_busy); end
        issue(32'd12, 32'd12);
        wait_done(-1, cyc, bok);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
        $display("txn a=12 b=12 after reset product=%h expected=%h cycles=%0d", product, exp, cyc);
        n_checks++;
        if (cyc !== 32) begin n_fail++; $display("FAIL restart_latency actual=%0d required=32", cyc); end
        n_checks++;
        if (product !== exp) begin n_fail++; $display("FAIL restart_product actual=%h required=%h", product, exp); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_during_run();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
